// File: rtl/mem_arb_pkg.sv
`default_nettype none
// mem_arb_pkg: state/owner types and byte-enable helpers shared by the
// unified memory arbiter and its lane-alignment datapath.

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_align.sv
`default_nettype none
// byte_lane_align: combinational byte-lane steering for lbu/sb versus lw/sw,
// producing byte enables, replicated store data and zero-extended load data.

module byte_lane_align
  import mem_arb_pkg::*;
(
  input  logic        byte_i,
  input  logic        we_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    be_o    = byte_i ? lane_be(lane_i) : BE_WORD;
    wdata_o = 32'd0;
    if (we_i) begin
      // Byte stores replicate the low byte so any enabled lane sees it.
      wdata_o = byte_i ? {4{wdata_i[7:0]}} : wdata_i;
    end
    rdata_o = byte_i ? {24'd0, rdata_i[{lane_i, 3'b000} +: 8]} : rdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// unified_mem_arbiter: shares one fixed-latency single-port memory between
// instruction fetch and load/store, with bounded data priority over fetch.

module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [3:0]    LAT_LOAD   = 4'(MEM_LAT - 1);

  state_e        state_q;
  owner_e        owner_q;
  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic [3:0]    lat_q;
  logic          byte_q;
  logic [1:0]    lane_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          if_valid_q;
  logic          d_valid_q;

  logic          grant_data;
  logic          grant_fetch;
  logic          align_byte;
  logic [1:0]    align_lane;
  logic [3:0]    align_be;
  logic [31:0]   align_wdata;
  logic [31:0]   align_rdata;
  logic          unused_if_lane;

  assign unused_if_lane = ^if_addr[1:0];

  // A full data streak hands the next slot to a waiting fetch.
  assign grant_data  = d_req && !(if_req && (streak_q == STREAK_MAX));
  assign grant_fetch = if_req && !grant_data;
  assign streak_d    = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;

  // Store-side lanes come straight from the inputs at grant; load extraction
  // later uses the captured lane so input changes mid-flight are harmless.
  assign align_byte = (state_q == IDLE) ? d_byte      : byte_q;
  assign align_lane = (state_q == IDLE) ? d_addr[1:0] : lane_q;

  byte_lane_align u_align (
    .byte_i  (align_byte),
    .we_i    (d_we),
    .lane_i  (align_lane),
    .wdata_i (d_wdata),
    .rdata_i (mem_rdata),
    .be_o    (align_be),
    .wdata_o (align_wdata),
    .rdata_o (align_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= FETCH;
      streak_q    <= '0;
      lat_q       <= '0;
      byte_q      <= 1'b0;
      lane_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_data) begin
            state_q     <= ACCESS;
            owner_q     <= DATA;
            streak_q    <= streak_d;
            byte_q      <= d_byte;
            lane_q      <= d_addr[1:0];
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_we;
            mem_be_q    <= align_be;
            mem_addr_q  <= {d_addr[AW-1:2], 2'b00};
            mem_wdata_q <= align_wdata;
          end else if (grant_fetch) begin
            state_q     <= ACCESS;
            owner_q     <= FETCH;
            streak_q    <= '0;
            byte_q      <= 1'b0;
            lane_q      <= '0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_be_q    <= BE_WORD;
            mem_addr_q  <= {if_addr[AW-1:2], 2'b00};
            mem_wdata_q <= '0;
          end
        end
        ACCESS: begin
          lat_q   <= LAT_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == '0) begin
            state_q <= DONE;
            if (owner_q == FETCH) begin
              if_rdata_q <= mem_rdata;
              if_valid_q <= 1'b1;
            end else begin
              d_valid_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= align_rdata;
              end
            end
          end else begin
            lat_q <= lat_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// tb_unified_mem_arbiter: directed steps with a completion scoreboard and a
// behavioural fixed-latency memory attached to the arbiter's memory port.

module tb_unified_mem_arbiter;

  localparam int AW          = 32;
  localparam int MEM_LAT     = 2;
  localparam int MAX_DSTREAK = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic          d_byte;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [31:0]   d_rdata;
  logic          d_valid;
  logic          mem_en;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  unified_mem_arbiter #(
    .AW          (AW),
    .MEM_LAT     (MEM_LAT),
    .MAX_DSTREAK (MAX_DSTREAK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_byte    (d_byte),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fetch;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          t0     = 0;
  logic [31:0] last_d = 32'd0;

  // Memory: read data appears MEM_LAT cycles after the mem_en cycle only.
  logic [31:0] mem [256];
  bit          pipe_v [MEM_LAT];
  logic [31:0] pipe_d [MEM_LAT];

  assign mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hBAD0_BAD0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    pipe_v[0] <= mem_en && !mem_we;
    pipe_d[0] <= mem[mem_addr[9:2]];
    for (int k = 1; k < MEM_LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_d[k] <= pipe_d[k-1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (if_valid === 1'b1 || d_valid === 1'b1)) begin
      if (sb.size() == 0) begin
        check("sb.unexpected_valid", {30'd0, if_valid, d_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb.if_valid", {31'd0, if_valid}, {31'd0, e.fetch});
        check("sb.d_valid", {31'd0, d_valid}, {31'd0, !e.fetch});
        if (e.fetch) check("sb.if_rdata", if_rdata, e.rdata);
        else         check("sb.d_rdata", d_rdata, e.rdata);
      end
    end
  end

  task automatic wait_en(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        c = cyc - t0;
        break;
      end
    end
  endtask

  // kind: 0 = fetch, 1 = data, 2 = either
  task automatic wait_valid(input int kind, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((kind != 1 && if_valid === 1'b1) || (kind != 0 && d_valid === 1'b1)) begin
        c = cyc - t0;
        break;
      end
    end
  endtask

  task automatic xact(input string tag, input bit fetch, input bit we, input bit byt,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] exp_be, input logic [31:0] exp_mw,
                      input logic [31:0] exp_rd);
    int c;
    exp_t e;
    e.fetch = fetch;
    e.rdata = (fetch || !we) ? exp_rd : last_d;
    sb.push_back(e);
    @(posedge clk); #1;
    if (fetch) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_we    = we;
      d_byte  = byt;
      d_addr  = addr;
      d_wdata = wdata;
    end
    t0 = cyc;
    wait_en(c);
    check({tag, ".en_lat"}, c, 32'd1);
    check({tag, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, ".mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    check({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, we && !fetch});
    if (we && !fetch) check({tag, ".mem_wdata"}, mem_wdata, exp_mw);
    // Disturb the request inputs; the transaction in flight must ignore them.
    if_addr = ~addr;
    d_addr  = ~addr;
    d_wdata = ~wdata;
    d_byte  = ~byt;
    wait_valid(fetch ? 0 : 1, c);
    check({tag, ".done_lat"}, c, 32'(2 + MEM_LAT));
    @(posedge clk); #1;
    if_req = 1'b0;
    d_req  = 1'b0;
    if (!fetch && !we) last_d = exp_rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    exp_t e;
    rst_n   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_byte  = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.mem_en", {31'd0, mem_en}, 32'd0);
    check("rst.valids", {30'd0, if_valid, d_valid}, 32'd0);
    check("rst.if_rdata", if_rdata, 32'd0);
    check("rst.d_rdata", d_rdata, 32'd0);
    check("rst.mem_be", {28'd0, mem_be}, 32'd0);
    rst_n = 1'b1;

    // Preload through the data port, then fetch.
    xact("wst10", 0, 1, 0, 32'h10, 32'h0050_0093, 4'b1111, 32'h0050_0093, 32'd0);
    xact("wst20", 0, 1, 0, 32'h20, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'd0);
    xact("fetch10", 1, 0, 0, 32'h10, 32'd0, 4'b1111, 32'd0, 32'h0050_0093);

    // Simultaneous requests: data wins, fetch follows after DONE.
    e.fetch = 1'b0; e.rdata = 32'h1234_5678; sb.push_back(e);
    e.fetch = 1'b1; e.rdata = 32'h0050_0093; sb.push_back(e);
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h10;
    t0 = cyc;
    wait_valid(1, c);
    check("arb.d_done", c, 32'(2 + MEM_LAT));
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_en(c);
    check("arb.f_en", c, 32'(MEM_LAT + 4));
    check("arb.f_addr", mem_addr, 32'h10);
    wait_valid(0, c);
    check("arb.f_done", c, 32'(2 * MEM_LAT + 5));
    @(posedge clk); #1;
    if_req = 1'b0;
    last_d = 32'h1234_5678;

    // Byte and word lane handling.
    xact("bst23", 0, 1, 1, 32'h23, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'd0);
    xact("bld22", 0, 0, 1, 32'h22, 32'd0, 4'b0100, 32'd0, 32'h0000_0034);
    xact("bld23", 0, 0, 1, 32'h23, 32'd0, 4'b1000, 32'd0, 32'h0000_00AB);
    xact("wld20", 0, 0, 0, 32'h20, 32'd0, 4'b1111, 32'd0, 32'hAB34_5678);
    xact("wst20b", 0, 1, 0, 32'h20, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'd0);
    xact("bld21", 0, 0, 1, 32'h21, 32'd0, 4'b0010, 32'd0, 32'h0000_0056);
    xact("wld20b", 0, 0, 0, 32'h20, 32'd0, 4'b1111, 32'd0, 32'h1234_5678);
    xact("wst40", 0, 1, 0, 32'h40, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'd0);
    check("wst40.d_rdata_kept", d_rdata, 32'h1234_5678);
    xact("wld42", 0, 0, 0, 32'h42, 32'd0, 4'b1111, 32'd0, 32'hDEAD_BEEF);
    xact("bst41", 0, 1, 1, 32'h41, 32'h1234_56CD, 4'b0010, 32'hCDCD_CDCD, 32'd0);
    xact("wld40", 0, 0, 0, 32'h40, 32'd0, 4'b1111, 32'd0, 32'hDEAD_CDEF);
    xact("bld20", 0, 0, 1, 32'h20, 32'd0, 4'b0001, 32'd0, 32'h0000_0078);

    // Streak limit: clear the streak with a fetch, then hold both requests.
    xact("fetch10b", 1, 0, 0, 32'h10, 32'd0, 4'b1111, 32'd0, 32'h0050_0093);
    for (int i = 0; i < 10; i++) begin
      e.fetch = (i == 4 || i == 9);
      e.rdata = e.fetch ? 32'h0050_0093 : 32'h1234_5678;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h10;
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_valid(2, c);
      check("streak.gap", c, (i == 0) ? 32'(2 + MEM_LAT) : 32'(MEM_LAT + 3));
      t0 = cyc;
    end
    @(posedge clk); #1;
    d_req  = 1'b0;
    if_req = 1'b0;
    last_d = 32'h1234_5678;

    // Reset during WAIT drops the access; a held request restarts cleanly.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h10;
    t0 = cyc;
    wait_en(c);
    check("rstw.en_lat", c, 32'd1);
    @(negedge clk);
    check("rstw.busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw.mem_en", {31'd0, mem_en}, 32'd0);
    check("rstw.busy", {31'd0, busy}, 32'd0);
    check("rstw.valids", {30'd0, if_valid, d_valid}, 32'd0);
    check("rstw.if_rdata", if_rdata, 32'd0);
    check("rstw.d_rdata", d_rdata, 32'd0);
    last_d = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    e.fetch = 1'b0; e.rdata = 32'h0050_0093; sb.push_back(e);
    rst_n = 1'b1;
    t0 = cyc;
    wait_en(c);
    check("rstw.re_en_lat", c, 32'd1);
    check("rstw.re_addr", mem_addr, 32'h10);
    wait_valid(1, c);
    check("rstw.re_done", c, 32'(2 + MEM_LAT));
    @(posedge clk); #1;
    d_req = 1'b0;
    last_d = 32'h0050_0093;

    xact("fetch10c", 1, 0, 0, 32'h10, 32'd0, 4'b1111, 32'd0, 32'h0050_0093);

    repeat (3) @(posedge clk);
    #1;
    check("end.busy", {31'd0, busy}, 32'd0);
    check("end.sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch stage and its data (load/store) stage. It is a controller FSM that grants one requester at a time, drives the memory port, waits out the memory latency, and returns data with a one-cycle valid pulse. It performs byte/word alignment for the byte-addressed load/store mode (lbu/sb vs lw/sw). The pipeline uses the requesters' pending state as its fetch and memory stall sources.

Parameters:
AW, 32, address width in bits
MEM_LAT, 2, memory read latency in cycles, legal range 1..15
MAX_DSTREAK, 4, maximum consecutive data grants while fetch is waiting

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held high until if_valid
if_addr  in  AW  fetch byte address
if_rdata  out  32  fetched word; holds its value until the next fetch completion
if_valid  out  1  one-cycle pulse marking fetch completion
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = store, 0 = load
d_byte  in  1  1 = byte access (lbu/sb), 0 = word access
d_addr  in  AW  data byte address
d_wdata  in  32  store data; byte stores use bits [7:0]
d_rdata  out  32  load result; unchanged by stores
d_valid  out  1  one-cycle pulse marking data completion, for loads and stores
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  4  byte enables
mem_addr  out  AW  word-aligned address: {addr[AW-1:2],2'b00}
mem_wdata  out  32  write data
mem_rdata  in  32  read data; valid MEM_LAT cycles after the mem_en cycle
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; owner FETCH; streak counter 0; latency counter 0; every output 0, including if_rdata and d_rdata.
- Reset asserted mid-transaction drops the transaction. No valid pulse is produced for it. A request still held after reset release is treated as new.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: requests are sampled here only.
  - Grant data if d_req is high, unless if_req is high and streak == MAX_DSTREAK; in that case grant fetch.
  - Otherwise grant fetch if if_req is high.
  - No request: stay in IDLE.
  - On a grant, register the owner and the memory command, then go to ACCESS.
- ACCESS (1 cycle): mem_en = 1; mem_we, mem_be, mem_addr, mem_wdata come from registers. Load the latency counter with MEM_LAT-1, then go to WAIT.
- WAIT: lasts exactly MEM_LAT cycles; mem_en = 0. In the last cycle, capture mem_rdata into the owner's rdata register. Stores do not capture. Then go to DONE.
- DONE (1 cycle): the owner's valid = 1; requests are not sampled. Then go to IDLE.
- Timing: a request sampled at the end of cycle t gives mem_en in cycle t+1 and valid in cycle t+2+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
- Streak counter: increments on each data grant, saturating at MAX_DSTREAK; clears to 0 on each fetch grant.
- Fetch is read-only: mem_we = 0, mem_be = 4'b1111.
- Word access: mem_be = 4'b1111; address bits [1:0] are ignored (misalignment is not flagged); store writes d_wdata.
- Byte access, lane = addr[1:0]:
  - mem_be = one-hot(lane).
  - Store: mem_wdata = {4{d_wdata[7:0]}}.
  - Load: d_rdata = {24'b0, mem_rdata[8*lane +: 8]}, zero-extended.
- A requester that drops req mid-transaction does not abort it. The transaction completes and the valid pulse is still issued.
- Address and data inputs are captured at grant. Later changes to them have no effect on the transaction in flight.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, ACCESS, WAIT, DONE};
  - the owner enum {FETCH, DATA};
  - constants BE_WORD = 4'b1111 and a function lane_be(lane) returning the one-hot byte enable.
- One combinational sub-module, byte_lane_align, computes mem_be, mem_wdata and load extraction from (byte, we, lane, wdata, rdata). The FSM and counters stay in the top module.

Test Plan:
- Fetch only, MEM_LAT=2, if_addr=0x10, memory word 0x00500093 -> mem_en in cycle 1 with mem_addr=0x10 and mem_be=1111; if_valid pulses in cycle 4 with if_rdata=0x00500093.
- if_req and d_req (word load at 0x20) asserted in the same cycle -> data granted first and d_valid in cycle 4; fetch mem_en in cycle 6; if_valid in cycle 9.
- Byte store d_addr=0x23, d_wdata=0x000000AB -> mem_we=1, mem_be=1000, mem_addr=0x20, mem_wdata=0xABABABAB. Then word 0x12345678 at 0x20 and a byte load from 0x22 -> d_rdata=0x00000034.
- d_req re-presented continuously and if_req held high, MAX_DSTREAK=4 -> 4 data grants, then the fetch grant, then data resumes with the streak restarting at 1.
- rst_n pulled low during WAIT -> mem_en, busy, valids and rdata regs go to 0 immediately with no valid pulse. After release with d_req held -> a fresh ACCESS one cycle later.
- Word store d_addr=0x40, d_wdata=0xDEADBEEF with prior d_rdata=0x12345678 -> mem_be=1111, d_valid pulses, d_rdata stays 0x12345678.
